// File: rtl/axi_rd_wr_arbiter_2to1.sv
// Two-master to one-slave AXI4 arbiter, one transaction in flight at a time.
// Ports:
//   aclk, arst_n          clock, async active-low reset
//   s0_ar*/s0_r*          IFU read port (read-only)
//   s1_ar*/s1_r*          LSU read side
//   s1_aw*/s1_w*/s1_b*    LSU write side
//   m_ar*/m_r*/m_aw*/m_w*/m_b*  merged master port toward the SRAM slave
module axi_rd_wr_arbiter_2to1 #(
    parameter int unsigned AXI_ADDR_W = 64,
    parameter int unsigned AXI_ID_W   = 8,
    parameter int unsigned AXI_DATA_W = 64
) (
    input  logic                    aclk,
    input  logic                    arst_n,
    // s0 AR / R
    input  logic                    s0_arvalid,
    output logic                    s0_arready,
    input  logic [AXI_ADDR_W-1:0]   s0_araddr,
    input  logic [7:0]              s0_arlen,
    input  logic [2:0]              s0_arsize,
    input  logic [1:0]              s0_arburst,
    input  logic                    s0_arlock,
    input  logic [3:0]              s0_arcache,
    input  logic [2:0]              s0_arprot,
    input  logic [3:0]              s0_arqos,
    input  logic [3:0]              s0_arregion,
    input  logic [AXI_ID_W-1:0]     s0_arid,
    output logic                    s0_rvalid,
    input  logic                    s0_rready,
    output logic [AXI_ID_W-1:0]     s0_rid,
    output logic [1:0]              s0_rresp,
    output logic [AXI_DATA_W-1:0]   s0_rdata,
    output logic                    s0_rlast,
    // s1 AR / R
    input  logic                    s1_arvalid,
    output logic                    s1_arready,
    input  logic [AXI_ADDR_W-1:0]   s1_araddr,
    input  logic [7:0]              s1_arlen,
    input  logic [2:0]              s1_arsize,
    input  logic [1:0]              s1_arburst,
    input  logic                    s1_arlock,
    input  logic [3:0]              s1_arcache,
    input  logic [2:0]              s1_arprot,
    input  logic [3:0]              s1_arqos,
    input  logic [3:0]              s1_arregion,
    input  logic [AXI_ID_W-1:0]     s1_arid,
    output logic                    s1_rvalid,
    input  logic                    s1_rready,
    output logic [AXI_ID_W-1:0]     s1_rid,
    output logic [1:0]              s1_rresp,
    output logic [AXI_DATA_W-1:0]   s1_rdata,
    output logic                    s1_rlast,
    // s1 AW / W / B
    input  logic                    s1_awvalid,
    output logic                    s1_awready,
    input  logic [AXI_ADDR_W-1:0]   s1_awaddr,
    input  logic [7:0]              s1_awlen,
    input  logic [2:0]              s1_awsize,
    input  logic [1:0]              s1_awburst,
    input  logic                    s1_awlock,
    input  logic [3:0]              s1_awcache,
    input  logic [2:0]              s1_awprot,
    input  logic [3:0]              s1_awqos,
    input  logic [3:0]              s1_awregion,
    input  logic [AXI_ID_W-1:0]     s1_awid,
    input  logic                    s1_wvalid,
    output logic                    s1_wready,
    input  logic [AXI_DATA_W-1:0]   s1_wdata,
    input  logic [AXI_DATA_W/8-1:0] s1_wstrb,
    input  logic                    s1_wlast,
    output logic                    s1_bvalid,
    input  logic                    s1_bready,
    output logic [AXI_ID_W-1:0]     s1_bid,
    output logic [1:0]              s1_bresp,
    // master port
    output logic                    m_arvalid,
    input  logic                    m_arready,
    output logic [AXI_ADDR_W-1:0]   m_araddr,
    output logic [7:0]              m_arlen,
    output logic [2:0]              m_arsize,
    output logic [1:0]              m_arburst,
    output logic                    m_arlock,
    output logic [3:0]              m_arcache,
    output logic [2:0]              m_arprot,
    output logic [3:0]              m_arqos,
    output logic [3:0]              m_arregion,
    output logic [AXI_ID_W-1:0]     m_arid,
    input  logic                    m_rvalid,
    output logic                    m_rready,
    input  logic [AXI_ID_W-1:0]     m_rid,
    input  logic [1:0]              m_rresp,
    input  logic [AXI_DATA_W-1:0]   m_rdata,
    input  logic                    m_rlast,
    output logic                    m_awvalid,
    input  logic                    m_awready,
    output logic [AXI_ADDR_W-1:0]   m_awaddr,
    output logic [7:0]              m_awlen,
    output logic [2:0]              m_awsize,
    output logic [1:0]              m_awburst,
    output logic                    m_awlock,
    output logic [3:0]              m_awcache,
    output logic [2:0]              m_awprot,
    output logic [3:0]              m_awqos,
    output logic [3:0]              m_awregion,
    output logic [AXI_ID_W-1:0]     m_awid,
    output logic                    m_wvalid,
    input  logic                    m_wready,
    output logic [AXI_DATA_W-1:0]   m_wdata,
    output logic [AXI_DATA_W/8-1:0] m_wstrb,
    output logic                    m_wlast,
    input  logic                    m_bvalid,
    output logic                    m_bready,
    input  logic [AXI_ID_W-1:0]     m_bid,
    input  logic [1:0]              m_bresp
);

    typedef struct packed {
        logic [AXI_ADDR_W-1:0] addr;
        logic [7:0]            len;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [3:0]            region;
        logic [AXI_ID_W-1:0]   id;
    } ax_t;

    typedef enum logic [2:0] {ST_IDLE, ST_RD0, ST_RD1, ST_WR1, ST_WB1} state_e;
    typedef enum logic [1:0] {SEL_NONE, SEL_S0R, SEL_S1R, SEL_S1W} sel_e;

    state_e state_q, state_d;
    sel_e   sel_q, sel_d, sel_c;
    logic   sel_lock_q, sel_lock_d;
    logic   last_grant_q, last_grant_d;

    ax_t s0_ar_ax, s1_ar_ax, s1_aw_ax, ar_out, aw_out;

    assign s0_ar_ax = {s0_araddr, s0_arlen, s0_arsize, s0_arburst, s0_arlock,
                       s0_arcache, s0_arprot, s0_arqos, s0_arregion, s0_arid};
    assign s1_ar_ax = {s1_araddr, s1_arlen, s1_arsize, s1_arburst, s1_arlock,
                       s1_arcache, s1_arprot, s1_arqos, s1_arregion, s1_arid};
    assign s1_aw_ax = {s1_awaddr, s1_awlen, s1_awsize, s1_awburst, s1_awlock,
                       s1_awcache, s1_awprot, s1_awqos, s1_awregion, s1_awid};

    // Source selection in IDLE; a driven-but-unaccepted request stays locked.
    always_comb begin
        sel_c = SEL_NONE;
        if (state_q == ST_IDLE) begin
            if (sel_lock_q) begin
                sel_c = sel_q;
            end else if (s0_arvalid && (s1_awvalid || s1_arvalid)) begin
                sel_c = last_grant_q ? SEL_S0R : (s1_awvalid ? SEL_S1W : SEL_S1R);
            end else if (s0_arvalid) begin
                sel_c = SEL_S0R;
            end else if (s1_awvalid) begin
                sel_c = SEL_S1W;
            end else if (s1_arvalid) begin
                sel_c = SEL_S1R;
            end
        end
    end

    // Address payload mux; unselected channel is driven to zero.
    always_comb begin
        ar_out = '0;
        aw_out = '0;
        case (sel_c)
            SEL_S0R: ar_out = s0_ar_ax;
            SEL_S1R: ar_out = s1_ar_ax;
            SEL_S1W: aw_out = s1_aw_ax;
            default: ;
        endcase
    end

    assign {m_araddr, m_arlen, m_arsize, m_arburst, m_arlock,
            m_arcache, m_arprot, m_arqos, m_arregion, m_arid} = ar_out;
    assign {m_awaddr, m_awlen, m_awsize, m_awburst, m_awlock,
            m_awcache, m_awprot, m_awqos, m_awregion, m_awid} = aw_out;

    assign m_arvalid  = (sel_c == SEL_S0R) || (sel_c == SEL_S1R);
    assign m_awvalid  = (sel_c == SEL_S1W);
    assign s0_arready = (sel_c == SEL_S0R) && m_arready;
    assign s1_arready = (sel_c == SEL_S1R) && m_arready;
    assign s1_awready = (sel_c == SEL_S1W) && m_awready;

    // Data/response routing by owning state; payloads fan out, valids are gated.
    assign s0_rvalid = (state_q == ST_RD0) && m_rvalid;
    assign s1_rvalid = (state_q == ST_RD1) && m_rvalid;
    assign m_rready  = ((state_q == ST_RD0) && s0_rready) || ((state_q == ST_RD1) && s1_rready);
    assign s0_rid    = m_rid;
    assign s0_rresp  = m_rresp;
    assign s0_rdata  = m_rdata;
    assign s0_rlast  = m_rlast;
    assign s1_rid    = m_rid;
    assign s1_rresp  = m_rresp;
    assign s1_rdata  = m_rdata;
    assign s1_rlast  = m_rlast;

    assign m_wvalid  = (state_q == ST_WR1) && s1_wvalid;
    assign s1_wready = (state_q == ST_WR1) && m_wready;
    assign m_wdata   = s1_wdata;
    assign m_wstrb   = s1_wstrb;
    assign m_wlast   = s1_wlast;

    assign s1_bvalid = (state_q == ST_WB1) && m_bvalid;
    assign m_bready  = (state_q == ST_WB1) && s1_bready;
    assign s1_bid    = m_bid;
    assign s1_bresp  = m_bresp;

    // Next-state, grant lock and round-robin pointer.
    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        sel_lock_d   = sel_lock_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if ((m_arvalid && m_arready) || (m_awvalid && m_awready)) begin
                    sel_lock_d   = 1'b0;
                    last_grant_d = (sel_c != SEL_S0R);
                    case (sel_c)
                        SEL_S0R: state_d = ST_RD0;
                        SEL_S1R: state_d = ST_RD1;
                        default: state_d = ST_WR1;
                    endcase
                end else if (m_arvalid || m_awvalid) begin
                    sel_lock_d = 1'b1;
                    sel_d      = sel_c;
                end
            end
            ST_RD0, ST_RD1: if (m_rvalid && m_rready && m_rlast) state_d = ST_IDLE;
            ST_WR1:         if (m_wvalid && m_wready && m_wlast) state_d = ST_WB1;
            ST_WB1:         if (m_bvalid && m_bready)            state_d = ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge aclk or negedge arst_n) begin
        if (!arst_n) begin
            state_q      <= ST_IDLE;
            sel_q        <= SEL_NONE;
            sel_lock_q   <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            sel_lock_q   <= sel_lock_d;
            last_grant_q <= last_grant_d;
        end
    end

endmodule
